// File: rtl/alu_seq_display_ctrl_if.sv
// Request/response and display bus of the ALU sequencing controller.
// Handshake: a request is accepted on a rising edge where req_valid && req_ready;
// req_valid is ignored while req_ready is low and nothing is queued.
interface alu_seq_display_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] a;
  logic [4:0] b;
  logic [2:0] sel;
  logic       busy;
  logic       done;
  logic [9:0] y;
  logic [6:0] seg;
  logic [3:0] an;
  logic [1:0] state;

  modport master (
    output req_valid, a, b, sel,
    input  req_ready, busy, done, y, seg, an, state
  );

  modport slave (
    input  req_valid, a, b, sel,
    output req_ready, busy, done, y, seg, an, state
  );
endinterface

// File: rtl/alu_seq_display_ctrl.sv
// 5-bit signed ALU sequencer: execute, binary-to-BCD (shift-add-3), commit,
// and a free-running 4-digit common-anode display scan of the committed result.
module alu_seq_display_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  alu_seq_display_ctrl_if.slave        bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_CONV   = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [1:0]        state;
  logic [4:0]        a_q, b_q;
  logic [2:0]        sel_q;
  logic signed [9:0] r;
  logic [9:0]        mag;
  logic [3:0]        hun, ten, one;
  logic [3:0]        bit_idx;
  logic [9:0]        y_q;
  logic [3:0]        dig_h, dig_t, dig_o;
  logic              sign;

  logic signed [9:0] ax, bx, alu_res;
  logic [21:0]       shv;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0011000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb begin
    ax = {{5{a_q[4]}}, a_q};
    bx = {{5{b_q[4]}}, b_q};
    alu_res = '0;
    case (sel_q)
      3'b001:  alu_res = ax & bx;
      3'b010:  alu_res = ax | bx;
      3'b011:  alu_res = ax ^ bx;
      3'b100:  alu_res = ~ax;
      3'b101:  alu_res = ax - bx;
      3'b110:  alu_res = ax + bx;
      3'b111:  alu_res = ax * bx;
      default: alu_res = '0;
    endcase
    // Adjust every nibble first, then shift one magnitude bit into the BCD chain.
    shv = {add3(hun), add3(ten), add3(one), mag} << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      r       <= '0;
      mag     <= '0;
      hun     <= '0;
      ten     <= '0;
      one     <= '0;
      bit_idx <= '0;
      y_q     <= '0;
      dig_h   <= '0;
      dig_t   <= '0;
      dig_o   <= '0;
      sign    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            sel_q <= bus.sel;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r       <= alu_res;
          mag     <= alu_res[9] ? -alu_res : alu_res;
          hun     <= '0;
          ten     <= '0;
          one     <= '0;
          bit_idx <= 4'd9;
          state   <= S_CONV;
        end
        S_CONV: begin
          {hun, ten, one, mag} <= shv;
          if (bit_idx == 4'd0) state <= S_COMMIT;
          else                 bit_idx <= bit_idx - 4'd1;
        end
        default: begin
          y_q   <= r;
          dig_h <= hun;
          dig_t <= ten;
          dig_o <= one;
          sign  <= r[9];
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_COMMIT);
  assign bus.y         = y_q;
  assign bus.state     = state;

  logic [CW-1:0] cnt;
  logic [1:0]    idx, idx_nxt;
  logic          wrap;
  logic [6:0]    seg_nxt, seg_q;
  logic [3:0]    an_q;

  // seg is chosen for the digit that an will select after this edge, so both move together.
  always_comb begin
    wrap    = (cnt == CW'(SCAN_DIV - 1));
    idx_nxt = wrap ? idx + 2'd1 : idx;
    case (idx_nxt)
      2'd0:    seg_nxt = seg_code(dig_o);
      2'd1:    seg_nxt = seg_code(dig_t);
      2'd2:    seg_nxt = seg_code(dig_h);
      default: seg_nxt = sign ? 7'b0111111 : 7'b1111111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= 2'd0;
      an_q  <= 4'b1110;
      seg_q <= 7'b1000000;
    end else begin
      cnt   <= wrap ? '0 : cnt + 1'b1;
      idx   <= idx_nxt;
      an_q  <= ~(4'b0001 << idx_nxt);
      seg_q <= seg_nxt;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;

endmodule

// File: tb/tb_alu_seq_display_ctrl.sv
// Directed bench for alu_seq_display_ctrl with a short scan divider.
module tb_alu_seq_display_ctrl;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [6:0] SEG0 = 7'b1000000;
  localparam logic [6:0] SEG1 = 7'b1111001;
  localparam logic [6:0] SEG2 = 7'b0100100;
  localparam logic [6:0] SEG5 = 7'b0010010;
  localparam logic [6:0] SEG6 = 7'b0000010;
  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  alu_seq_display_ctrl_if bus ();

  alu_seq_display_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic do_op(input logic [4:0] ia, input logic [4:0] ib, input logic [2:0] isel,
                       output int lat, output int pulses);
    @(negedge clk);
    bus.a = ia; bus.b = ib; bus.sel = isel; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; pulses = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (bus.done) begin
        pulses++;
        if (lat == 0) lat = n;
      end
    end
  endtask

  task automatic get_digits(output logic [6:0] d0, output logic [6:0] d1,
                            output logic [6:0] d2, output logic [6:0] d3, output bit ok);
    logic [3:0] got;
    got = '0; d0 = 'x; d1 = 'x; d2 = 'x; d3 = 'x;
    repeat (2) @(negedge clk);
    for (int n = 0; n < 40 && got != 4'hF; n++) begin
      @(negedge clk);
      case (bus.an)
        4'b1110: begin d0 = bus.seg; got[0] = 1'b1; end
        4'b1101: begin d1 = bus.seg; got[1] = 1'b1; end
        4'b1011: begin d2 = bus.seg; got[2] = 1'b1; end
        4'b0111: begin d3 = bus.seg; got[3] = 1'b1; end
        default: ;
      endcase
    end
    ok = (got == 4'hF);
  endtask

  task automatic test_reset();
    logic [3:0] an_seq [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    an_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_cmp++; if (bus.y !== 10'd0) begin n_bad++; $display("FAIL reset_y got=%h exp=000", bus.y); end
    n_cmp++; if (bus.an !== 4'b1110) begin n_bad++; $display("FAIL reset_an got=%b exp=1110", bus.an); end
    n_cmp++; if (bus.seg !== SEG0) begin n_bad++; $display("FAIL reset_seg got=%b exp=%b", bus.seg, SEG0); end
    n_cmp++; if (bus.state !== 2'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_an  = an_seq[(k / 4) % 4];
      exp_seg = (((k / 4) % 4) == 3) ? BLANK : SEG0;
      n_cmp++; if (bus.an !== exp_an) begin n_bad++; $display("FAIL scan_an k=%0d got=%b exp=%b", k, bus.an, exp_an); end
      n_cmp++; if (bus.seg !== exp_seg) begin n_bad++; $display("FAIL scan_seg k=%0d got=%b exp=%b", k, bus.seg, exp_seg); end
    end
  endtask

  task automatic test_add();
    int lat, pulses; logic [6:0] d0, d1, d2, d3; bit ok;
    do_op(5'd3, 5'b11011, 3'b110, lat, pulses);
    n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL add_latency got=%0d exp=12", lat); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL add_done_pulses got=%0d exp=1", pulses); end
    n_cmp++; if (bus.y !== 10'h3FE) begin n_bad++; $display("FAIL add_y got=%h exp=3fe", bus.y); end
    get_digits(d0, d1, d2, d3, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL add_scan got=%b exp=1", ok); end
    n_cmp++; if (d0 !== SEG2) begin n_bad++; $display("FAIL add_ones got=%b exp=%b", d0, SEG2); end
    n_cmp++; if (d1 !== SEG0) begin n_bad++; $display("FAIL add_tens got=%b exp=%b", d1, SEG0); end
    n_cmp++; if (d2 !== SEG0) begin n_bad++; $display("FAIL add_hund got=%b exp=%b", d2, SEG0); end
    n_cmp++; if (d3 !== MINUS) begin n_bad++; $display("FAIL add_sign got=%b exp=%b", d3, MINUS); end
  endtask

  task automatic test_mul_not();
    int lat, pulses; logic [6:0] d0, d1, d2, d3; bit ok;
    do_op(5'b10000, 5'b10000, 3'b111, lat, pulses);
    n_cmp++; if (bus.y !== 10'd256) begin n_bad++; $display("FAIL mul_y got=%h exp=100", bus.y); end
    get_digits(d0, d1, d2, d3, ok);
    n_cmp++; if (d0 !== SEG6) begin n_bad++; $display("FAIL mul_ones got=%b exp=%b", d0, SEG6); end
    n_cmp++; if (d1 !== SEG5) begin n_bad++; $display("FAIL mul_tens got=%b exp=%b", d1, SEG5); end
    n_cmp++; if (d2 !== SEG2) begin n_bad++; $display("FAIL mul_hund got=%b exp=%b", d2, SEG2); end
    n_cmp++; if (d3 !== BLANK) begin n_bad++; $display("FAIL mul_sign got=%b exp=%b", d3, BLANK); end
    do_op(5'd5, 5'd0, 3'b100, lat, pulses);
    n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL not_latency got=%0d exp=12", lat); end
    n_cmp++; if (bus.y !== 10'h3FA) begin n_bad++; $display("FAIL not_y got=%h exp=3fa", bus.y); end
    get_digits(d0, d1, d2, d3, ok);
    n_cmp++; if (d0 !== SEG6) begin n_bad++; $display("FAIL not_ones got=%b exp=%b", d0, SEG6); end
    n_cmp++; if (d3 !== MINUS) begin n_bad++; $display("FAIL not_sign got=%b exp=%b", d3, MINUS); end
  endtask

  task automatic test_back_to_back();
    int dones, e;
    dones = 0;
    for (int i = 0; i <= 26; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        e = i - 1;
        if (bus.done) dones++;
        if (e <= 24 && e != 12) begin
          n_cmp++; if ({bus.busy, bus.req_ready} !== 2'b10) begin
            n_bad++; $display("FAIL b2b_busy e=%0d got=%b exp=10", e, {bus.busy, bus.req_ready});
          end
        end
        if (e == 12) begin
          n_cmp++; if (bus.y !== 10'd1) begin n_bad++; $display("FAIL b2b_y1 got=%h exp=001", bus.y); end
          n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got=%b exp=1", bus.req_ready); end
        end
        if (e == 25) begin
          n_cmp++; if (bus.y !== 10'd14) begin n_bad++; $display("FAIL b2b_y2 got=%h exp=00e", bus.y); end
        end
      end
      if (i < 26) begin
        bus.a = 5'(i); bus.b = 5'd1; bus.sel = 3'b110; bus.req_valid = 1'b1;
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    n_cmp++; if (dones !== 2) begin n_bad++; $display("FAIL b2b_dones got=%0d exp=2", dones); end
  endtask

  task automatic test_reset_mid();
    int lat, pulses, dones; logic [6:0] d0, d1, d2, d3; bit ok;
    @(negedge clk);
    bus.a = 5'd7; bus.b = 5'd7; bus.sel = 3'b111; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.state !== 2'd2) begin n_bad++; $display("FAIL mid_in_conv got=%0d exp=2", bus.state); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (bus.y !== 10'd0) begin n_bad++; $display("FAIL mid_y got=%h exp=000", bus.y); end
    n_cmp++; if ({bus.req_ready, bus.busy, bus.done} !== 3'b100) begin
      n_bad++; $display("FAIL mid_flags got=%b exp=100", {bus.req_ready, bus.busy, bus.done});
    end
    n_cmp++; if (bus.an !== 4'b1110) begin n_bad++; $display("FAIL mid_an got=%b exp=1110", bus.an); end
    n_cmp++; if (bus.seg !== SEG0) begin n_bad++; $display("FAIL mid_seg got=%b exp=%b", bus.seg, SEG0); end
    dones = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL mid_no_done got=%0d exp=0", dones); end
    get_digits(d0, d1, d2, d3, ok);
    n_cmp++; if (d3 !== BLANK) begin n_bad++; $display("FAIL mid_sign got=%b exp=%b", d3, BLANK); end
    do_op(5'd2, 5'd3, 3'b110, lat, pulses);
    n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL mid_fresh_latency got=%0d exp=12", lat); end
    n_cmp++; if (bus.y !== 10'd5) begin n_bad++; $display("FAIL mid_fresh_y got=%h exp=005", bus.y); end
    get_digits(d0, d1, d2, d3, ok);
    n_cmp++; if (d0 !== SEG5) begin n_bad++; $display("FAIL mid_fresh_ones got=%b exp=%b", d0, SEG5); end
  endtask

  task automatic test_zero_sub();
    int lat, pulses; logic [6:0] d0, d1, d2, d3; bit ok;
    do_op(5'd7, 5'd7, 3'b000, lat, pulses);
    n_cmp++; if (bus.y !== 10'd0) begin n_bad++; $display("FAIL zero_y got=%h exp=000", bus.y); end
    get_digits(d0, d1, d2, d3, ok);
    n_cmp++; if ({d3, d2, d1, d0} !== {BLANK, SEG0, SEG0, SEG0}) begin
      n_bad++; $display("FAIL zero_digits got=%b exp=%b", {d3, d2, d1, d0}, {BLANK, SEG0, SEG0, SEG0});
    end
    do_op(5'b11111, 5'd15, 3'b101, lat, pulses);
    n_cmp++; if (bus.y !== 10'h3F0) begin n_bad++; $display("FAIL sub_y got=%h exp=3f0", bus.y); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL sub_done_pulses got=%0d exp=1", pulses); end
    get_digits(d0, d1, d2, d3, ok);
    n_cmp++; if ({d3, d2, d1, d0} !== {MINUS, SEG0, SEG1, SEG6}) begin
      n_bad++; $display("FAIL sub_digits got=%b exp=%b", {d3, d2, d1, d0}, {MINUS, SEG0, SEG1, SEG6});
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sel = '0;
    test_reset();
    test_add();
    test_mul_not();
    test_back_to_back();
    test_reset_mid();
    test_zero_sub();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
